// File: rtl/cvxif_group_pkg.sv
// Shared types and helpers for the CVXIF group dispatcher.
// Holds the writeback entry layout, the round-robin step and the default opcode map.
package cvxif_group_pkg;

    localparam int OUT_W = 64;
    localparam int ID_W  = 3;

    typedef logic [3:0] grp_idx_t;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [ID_W-1:0]  id;
    } wb_entry_t;

    // Index 0 is the lowest boundary; each group owns [bound[g], bound[g+1]).
    localparam logic [4:0][31:0] DEF_OPCODE_BOUND = {32'd32, 32'd24, 32'd16, 32'd8, 32'd0};

    function automatic grp_idx_t next_rr(input grp_idx_t cur, input int num);
        if (int'(cur) >= num - 1) begin
            return '0;
        end
        return cur + 4'd1;
    endfunction

endpackage

// File: rtl/cvxif_group_fifo.sv
// Generic circular FIFO (power-of-two or unit depth).
// Latency: a pushed word reaches the head on the following cycle.
// Backpressure: none; the caller bounds occupancy, push when full and pop when empty are dropped.
module cvxif_group_fifo #(
    parameter int Width = 8,
    parameter int Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [Width-1:0] push_dat,
    input  logic             pop,
    output logic [Width-1:0] pop_dat,
    output logic             empty
);
    localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW:0]      used;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (used == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (used != FULL_CNT);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop)  rd_ptr <= inc(rd_ptr);
            used <= used + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/cvxif_group_slot.sv
// Per-group tracking: outstanding ids, completed results and the outstanding count.
// Latency: a done pulse makes its result visible at the head the next cycle.
// Backpressure: full asserts at Depth outstanding; results wait until popped by the arbiter.
module cvxif_group_slot
    import cvxif_group_pkg::*;
#(
    parameter int Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_id,
    input  logic [ID_W-1:0]  id,
    input  logic             done,
    input  logic [OUT_W-1:0] data,
    input  logic             pop,
    output logic             full,
    output logic             res_vld,
    output wb_entry_t        head,
    output logic             spurious
);
    localparam int CW = $clog2(Depth + 1);

    logic [CW-1:0]   cnt;
    logic [ID_W-1:0] id_head;
    logic            id_empty, res_empty, retire;

    // A done with nothing outstanding is flagged but never retires anything.
    assign retire   = done & ~id_empty;
    assign spurious = done & id_empty;
    assign res_vld  = ~res_empty;
    assign full     = (cnt == CW'(Depth));

    cvxif_group_fifo #(.Width(ID_W), .Depth(Depth)) u_id_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push     (push_id),
        .push_dat (id),
        .pop      (retire),
        .pop_dat  (id_head),
        .empty    (id_empty)
    );

    cvxif_group_fifo #(.Width($bits(wb_entry_t)), .Depth(Depth)) u_res_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push     (retire),
        .push_dat ({data, id_head}),
        .pop      (pop),
        .pop_dat  (head),
        .empty    (res_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else begin
            case ({push_id, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/cvxif_group_dispatch.sv
// Opcode-decoded dispatch to NumGroups accelerator groups with round-robin result writeback.
// Latency: exec/fill/pick are combinational; a result is offered on wb one cycle after its done.
// Backpressure: busy_o when the decoded group is full; wb grant held while wb_ready_i is low.
// Optional CVXIF_GROUP_PERF_EN adds per-group retire counters and a writeback stall counter.
module cvxif_group_dispatch
    import cvxif_group_pkg::*;
#(
    parameter int NumGroups   = 4,
    parameter int Depth       = 2,
    parameter int OpcodeWidth = 6,
    parameter int OutWidth    = OUT_W,
    parameter int IdWidth     = ID_W,
    parameter logic [NumGroups:0][31:0] OpcodeBound = DEF_OPCODE_BOUND
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          exec_i,
    input  logic [OpcodeWidth-1:0]        opcode_i,
    input  logic [IdWidth-1:0]            instr_id_i,
    input  logic                          fill_vld_i,
    input  logic                          pick_vld_i,
    output logic                          busy_o,
    output logic                          invalid_instr_o,
    output logic [NumGroups-1:0]          grp_exec_o,
    output logic [NumGroups-1:0]          grp_fill_o,
    input  logic [NumGroups-1:0]          grp_done_i,
    input  logic [NumGroups*OutWidth-1:0] grp_data_i,
    output logic [OutWidth-1:0]           pick_data_o,
    output logic                          wb_valid_o,
    input  logic                          wb_ready_i,
    output logic [OutWidth-1:0]           wb_data_o,
    output logic [IdWidth-1:0]            wb_id_o,
    output logic                          err_o
`ifdef CVXIF_GROUP_PERF_EN
    ,
    output logic [NumGroups-1:0][31:0]    perf_cnt_o,
    output logic [31:0]                   stall_cnt_o
`endif
);
    logic [31:0]          opc;
    logic [NumGroups-1:0] sel, full, res_vld, spurious, pop;
    wb_entry_t            head [NumGroups];
    wb_entry_t            wb_ent;
    grp_idx_t             gnt, rr, lock_idx;
    logic                 locked, bypass, hs;

    assign opc             = {{(32-OpcodeWidth){1'b0}}, opcode_i};
    assign invalid_instr_o = (opc >= OpcodeBound[NumGroups]);
    assign busy_o          = |(sel & full);
    assign grp_exec_o      = sel & {NumGroups{exec_i & ~busy_o}};
    assign grp_fill_o      = sel & {NumGroups{fill_vld_i}};
    assign bypass          = pick_vld_i & ~exec_i;
    assign wb_valid_o      = (|res_vld) & ~bypass;
    assign hs              = wb_valid_o & wb_ready_i;
    assign wb_data_o       = wb_ent.data;
    assign wb_id_o         = wb_ent.id;

    always_comb begin : decode
        sel         = '0;
        pick_data_o = '0;
        for (int g = 0; g < NumGroups; g++) begin
            if (opc >= OpcodeBound[g] && opc < OpcodeBound[g+1]) begin
                sel[g]      = 1'b1;
                pick_data_o = grp_data_i[g*OutWidth +: OutWidth];
            end
        end
    end

    // A stalled offer keeps its grant so the writeback payload cannot change under the consumer.
    always_comb begin : arbiter
        int   k;
        logic found;
        k     = 0;
        found = 1'b0;
        gnt   = lock_idx;
        if (!locked) begin
            gnt = '0;
            for (int i = 0; i < NumGroups; i++) begin
                k = int'(rr) + i;
                if (k >= NumGroups) k = k - NumGroups;
                if (!found && res_vld[k]) begin
                    gnt   = grp_idx_t'(k);
                    found = 1'b1;
                end
            end
        end
        wb_ent = head[0];
        pop    = '0;
        for (int g = 0; g < NumGroups; g++) begin
            if (gnt == grp_idx_t'(g)) wb_ent = head[g];
            pop[g] = hs && (gnt == grp_idx_t'(g));
        end
    end

    for (genvar g = 0; g < NumGroups; g++) begin : g_slot
        cvxif_group_slot #(.Depth(Depth)) u_slot (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .push_id  (grp_exec_o[g]),
            .id       (instr_id_i),
            .done     (grp_done_i[g]),
            .data     (grp_data_i[g*OutWidth +: OutWidth]),
            .pop      (pop[g]),
            .full     (full[g]),
            .res_vld  (res_vld[g]),
            .head     (head[g]),
            .spurious (spurious[g])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr       <= '0;
            locked   <= 1'b0;
            lock_idx <= '0;
            err_o    <= 1'b0;
        end else begin
            if (hs) rr <= next_rr(gnt, NumGroups);
            if (wb_valid_o) begin
                locked   <= ~wb_ready_i;
                lock_idx <= gnt;
            end
            if (|spurious) err_o <= 1'b1;
        end
    end

`ifdef CVXIF_GROUP_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_cnt_o  <= '0;
            stall_cnt_o <= '0;
        end else begin
            for (int g = 0; g < NumGroups; g++) begin
                if (pop[g]) perf_cnt_o[g] <= perf_cnt_o[g] + 32'd1;
            end
            if (wb_valid_o && !wb_ready_i) stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cvxif_group_dispatch.sv
// Bench for cvxif_group_dispatch: directed scenarios with literal expectations, then random traffic
// compared every cycle against a queue-based model of the dispatcher.
module tb_cvxif_group_dispatch;
    localparam int NG    = 4;
    localparam int DEPTH = 2;
    localparam int OW    = 64;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           exec, fill, pick, ready;
    logic [5:0]     opcode;
    logic [2:0]     id;
    logic [NG-1:0]  done;
    logic [NG*OW-1:0] gdata;
    logic           busy, invalid, wb_valid, err;
    logic [NG-1:0]  gexec, gfill;
    logic [OW-1:0]  pick_data, wb_data;
    logic [2:0]     wb_id;
`ifdef CVXIF_GROUP_PERF_EN
    logic [NG-1:0][31:0] perf_cnt;
    logic [31:0]         stall_cnt;
`endif

    int total = 0;
    int bad   = 0;
    bit running = 1'b0;

    // Model: outstanding ids and pending results per group, plus arbitration state.
    logic [2:0]  idq    [NG][$];
    logic [63:0] resq_d [NG][$];
    logic [2:0]  resq_i [NG][$];
    int          m_rr, m_lockg;
    bit          m_locked, m_err;
    int unsigned m_perf [NG];
    int unsigned m_stall;

    int bound [NG+1] = '{0, 8, 16, 24, 32};

    cvxif_group_dispatch dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .exec_i          (exec),
        .opcode_i        (opcode),
        .instr_id_i      (id),
        .fill_vld_i      (fill),
        .pick_vld_i      (pick),
        .busy_o          (busy),
        .invalid_instr_o (invalid),
        .grp_exec_o      (gexec),
        .grp_fill_o      (gfill),
        .grp_done_i      (done),
        .grp_data_i      (gdata),
        .pick_data_o     (pick_data),
        .wb_valid_o      (wb_valid),
        .wb_ready_i      (ready),
        .wb_data_o       (wb_data),
        .wb_id_o         (wb_id),
        .err_o           (err)
`ifdef CVXIF_GROUP_PERF_EN
        ,
        .perf_cnt_o      (perf_cnt),
        .stall_cnt_o     (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int dec(input logic [5:0] op);
        for (int g = 0; g < NG; g++)
            if (int'(op) >= bound[g] && int'(op) < bound[g+1]) return g;
        return -1;
    endfunction

    function automatic int grant();
        if (m_locked) return m_lockg;
        for (int i = 0; i < NG; i++) begin
            int k;
            k = (m_rr + i) % NG;
            if (resq_d[k].size() > 0) return k;
        end
        return -1;
    endfunction

    always @(negedge clk) begin : cmp
        int g, gg, cn;
        bit bsy, vld;
        logic [NG-1:0] ee, ef;
        if (running) begin
            if (!rst_n) begin
                for (int q = 0; q < NG; q++) begin
                    idq[q].delete(); resq_d[q].delete(); resq_i[q].delete(); m_perf[q] = 0;
                end
                m_rr = 0; m_lockg = 0; m_locked = 0; m_err = 0; m_stall = 0;
            end
            g   = dec(opcode);
            cn  = (g >= 0) ? idq[g].size() + resq_d[g].size() : 0;
            bsy = (g >= 0) && (cn == DEPTH);
            ee  = (g >= 0 && exec && !bsy) ? NG'(1 << g) : '0;
            ef  = (g >= 0 && fill) ? NG'(1 << g) : '0;
            gg  = grant();
            vld = (gg >= 0) && !(pick && !exec);
            chk("invalid", invalid, opcode >= 6'd32);
            chk("busy", busy, bsy);
            chk("grp_exec", gexec, ee);
            chk("grp_fill", gfill, ef);
            if (g >= 0) chk("pick_data", pick_data, gdata[g*OW +: OW]);
            chk("wb_valid", wb_valid, vld);
            if (vld) begin
                chk("wb_id", wb_id, resq_i[gg][0]);
                chk("wb_data", wb_data, resq_d[gg][0]);
            end
            chk("err", err, m_err);
`ifdef CVXIF_GROUP_PERF_EN
            for (int q = 0; q < NG; q++) chk("perf_cnt", perf_cnt[q], m_perf[q]);
            chk("stall_cnt", stall_cnt, m_stall);
`endif
            if (rst_n) begin
                for (int d = 0; d < NG; d++) begin
                    if (done[d]) begin
                        if (idq[d].size() == 0) m_err = 1;
                        else begin
                            resq_d[d].push_back(gdata[d*OW +: OW]);
                            resq_i[d].push_back(idq[d].pop_front());
                        end
                    end
                end
                if (ee != '0) idq[g].push_back(id);
                if (vld && ready) begin
                    void'(resq_d[gg].pop_front());
                    void'(resq_i[gg].pop_front());
                    m_rr = (gg + 1) % NG;
                    m_perf[gg]++;
                end
                if (vld && !ready) m_stall++;
                if (vld) begin
                    m_locked = !ready;
                    m_lockg  = gg;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic at_neg();
        @(negedge clk); #1;
    endtask

    task automatic set_data(input int g, input logic [63:0] v);
        gdata[g*OW +: OW] = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cyc(); cyc(); rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, total=%0d", total);
        $fatal(1);
    end

    initial begin
        rst_n = 0; exec = 0; fill = 0; pick = 0; done = '0; ready = 1;
        opcode = '0; id = '0;
        for (int g = 0; g < NG; g++) set_data(g, {$urandom, $urandom});
        running = 1'b1;
        cyc(); at_neg();
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        cyc(); rst_n = 1'b1;

        // Single instruction to group 1.
        opcode = 6'd9; id = 3'd5; exec = 1;
        at_neg(); chk("t1_exec", gexec, 4'b0010);
        cyc(); exec = 0; cyc(); cyc();
        set_data(1, 64'hAB); done = 4'b0010; cyc(); done = '0;
        at_neg();
        chk("t1_wb_valid", wb_valid, 1);
        chk("t1_wb_id", wb_id, 5);
        chk("t1_wb_data", wb_data, 64'hAB);
        cyc(); at_neg(); chk("t1_drained", wb_valid, 0);

        // Fill group 0 to depth.
        cyc(); opcode = 6'd3; exec = 1; id = 3'd1; cyc(); id = 3'd2; cyc(); id = 3'd3;
        at_neg(); chk("t2_busy", busy, 1); chk("t2_exec_blocked", gexec, 4'b0000);
        cyc(); exec = 0; set_data(0, 64'h11); done = 4'b0001; cyc(); done = '0;
        at_neg(); chk("t2_wb_id", wb_id, 1); chk("t2_busy_hold", busy, 1);
        cyc(); at_neg(); chk("t2_busy_free", busy, 0);
        cyc(); set_data(0, 64'h22); done = 4'b0001; cyc(); done = '0;
        at_neg(); chk("t2_wb_id2", wb_id, 2);
        cyc();

        // Simultaneous done on groups 0..2 after a fresh reset.
        do_reset();
        exec = 1; opcode = 6'd0; id = 3'd1; cyc(); opcode = 6'd8; id = 3'd2; cyc();
        opcode = 6'd16; id = 3'd3; cyc(); exec = 0; done = 4'b0111; cyc(); done = '0;
        for (int k = 0; k < 3; k++) begin
            at_neg(); chk("t3_order", wb_id, 3'(k + 1)); cyc();
        end
        exec = 1; opcode = 6'd24; id = 3'd4; cyc(); opcode = 6'd0; id = 3'd5; cyc();
        exec = 0; done = 4'b1001; cyc(); done = '0;
        at_neg(); chk("t3_rr_wrap", wb_id, 4); cyc();
        at_neg(); chk("t3_rr_next", wb_id, 5); cyc();

        // Backpressure with two requesters.
        ready = 0; exec = 1; opcode = 6'd16; id = 3'd6; cyc(); opcode = 6'd24; id = 3'd7; cyc();
        exec = 0; set_data(2, 64'hC2); set_data(3, 64'hC3); done = 4'b1100; cyc(); done = '0;
        for (int k = 0; k < 4; k++) begin
            set_data(2, {$urandom, $urandom});
            at_neg();
            chk("t4_valid", wb_valid, 1);
            chk("t4_stable_id", wb_id, 6);
            chk("t4_stable_data", wb_data, 64'hC2);
            cyc();
        end
        ready = 1;
`ifdef CVXIF_GROUP_PERF_EN
        at_neg(); chk("t4_stall_cnt", stall_cnt, 4);
`endif
        cyc(); at_neg(); chk("t4_second", wb_id, 7); cyc();

        // Bypass holds back a pending result for one cycle.
        exec = 1; opcode = 6'd8; id = 3'd2; cyc(); exec = 0;
        set_data(1, 64'hD1); done = 4'b0010; cyc(); done = '0;
        pick = 1; set_data(1, 64'hE1);
        at_neg(); chk("t5_bypass_valid", wb_valid, 0); chk("t5_pick_data", pick_data, 64'hE1);
        cyc(); pick = 0;
        at_neg(); chk("t5_after_valid", wb_valid, 1); chk("t5_after_id", wb_id, 2);
        chk("t5_after_data", wb_data, 64'hD1);
        cyc();

        // Invalid opcode and spurious done.
        opcode = 6'd40; exec = 1;
        at_neg(); chk("t6_invalid", invalid, 1); chk("t6_no_exec", gexec, 4'b0000);
        cyc(); exec = 0; done = 4'b1000; cyc(); done = '0;
        at_neg(); chk("t6_err", err, 1);
        cyc(); cyc(); at_neg(); chk("t6_err_sticky", err, 1);
        cyc(); rst_n = 0;
        at_neg(); chk("t6_err_cleared", err, 0);
        cyc(); rst_n = 1;

        // Random traffic with one mid-run reset.
        for (int n = 0; n < 3000; n++) begin
            rst_n  = (n != 1500);
            exec   = ($urandom_range(0, 99) < 40);
            opcode = 6'($urandom_range(0, 47));
            id     = 3'($urandom);
            fill   = $urandom_range(0, 1);
            pick   = ($urandom_range(0, 99) < 15);
            ready  = ($urandom_range(0, 99) < 65);
            for (int g = 0; g < NG; g++) begin
                set_data(g, {$urandom, $urandom});
                done[g] = (idq[g].size() > 0) && ($urandom_range(0, 99) < 35);
            end
            cyc();
        end
        exec = 0; fill = 0; pick = 0; done = '0; ready = 1;
        cyc(); cyc(); at_neg();
        running = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
